// File: rtl/fb_line_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_line_fetch_pkg
// Description : Constants shared by the framebuffer line fetcher.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_line_fetch_pkg;

  // Framebuffer words pack three colour channels as {ch2, ch1, ch0}.
  localparam int FB_CHANNELS = 3;

endpackage
`default_nettype wire

// File: rtl/fb_line_fetch.sv
`default_nettype none
// ============================================================================
// Module      : fb_line_fetch
// Description : Reads one framebuffer line per linebuffer request, delays the
//               read enable by the BRAM latency to form the linebuffer write
//               enable, and walks through the frame line by line with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_line_fetch
  import fb_line_fetch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN   = 160,
  parameter int LINES = 120,
  parameter int LAT   = 1,
  parameter int ADDRW = $clog2(LEN * LINES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         frame_start,
  input  logic                         data_req,
  output logic                         fb_en,
  output logic [ADDRW-1:0]             fb_addr,
  input  logic [FB_CHANNELS*WIDTH-1:0] fb_data,
  output logic                         line_en,
  output logic [WIDTH-1:0]             din_0,
  output logic [WIDTH-1:0]             din_1,
  output logic [WIDTH-1:0]             din_2,
  output logic                         busy,
  output logic                         overrun
);

  localparam int c_xw = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int c_lw = (LINES > 1) ? $clog2(LINES) : 1;

  localparam logic [c_xw-1:0]  c_x_last     = c_xw'(LEN - 1);
  localparam logic [c_xw-1:0]  c_drain_last = c_xw'(LAT - 1);
  localparam logic [c_xw-1:0]  c_x_one      = c_xw'(1);
  localparam logic [c_lw-1:0]  c_line_last  = c_lw'(LINES - 1);
  localparam logic [c_lw-1:0]  c_line_one   = c_lw'(1);
  localparam logic [ADDRW-1:0] c_len        = ADDRW'(LEN);
  localparam logic [ADDRW-1:0] c_addr_one   = ADDRW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  fetch_state_t     r_state;
  fetch_state_t     w_next_state;
  logic [c_xw-1:0]  r_x;
  logic [c_lw-1:0]  r_line_cnt;
  logic [ADDRW-1:0] r_line_base;
  logic [ADDRW-1:0] r_fetch_base;
  logic [ADDRW-1:0] r_addr;
  logic             r_skip;
  logic             r_overrun;
  logic [LAT-1:0]   r_dly;
  logic             w_busy;
  logic             w_done;
  logic [ADDRW-1:0] w_start_base;

  assign w_busy = (r_state != IDLE);
  // Normal completion: last drain cycle with no abort arriving on top of it.
  assign w_done = (r_state == DRAIN) && !data_req && (r_x == c_drain_last);
  // A frame_start in the same cycle forces line 0; a restart re-reads the
  // line that was being fetched, a fresh start reads the current line.
  assign w_start_base = frame_start     ? '0 :
                        (r_state == IDLE) ? r_line_base : r_fetch_base;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: any request restarts FETCH, otherwise count through.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (data_req) w_next_state = FETCH;
      FETCH:   if (data_req) w_next_state = FETCH;
               else if (r_x == c_x_last) w_next_state = DRAIN;
      DRAIN:   if (data_req) w_next_state = FETCH;
               else if (r_x == c_drain_last) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode: reads are issued only in FETCH, address held at 0 otherwise.
  always_comb begin
    fb_en   = (r_state == FETCH);
    fb_addr = (r_state == FETCH) ? r_addr : '0;
    busy    = w_busy;
    overrun = r_overrun;
    line_en = r_dly[LAT-1];
    din_0   = fb_data[WIDTH-1:0];
    din_1   = fb_data[2*WIDTH-1:WIDTH];
    din_2   = fb_data[3*WIDTH-1:2*WIDTH];
  end

  // Pixel / drain counter and running read address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x          <= '0;
      r_addr       <= '0;
      r_fetch_base <= '0;
    end else begin
      if (data_req) begin
        r_x          <= '0;
        r_addr       <= w_start_base;
        r_fetch_base <= w_start_base;
      end else if (r_state == FETCH) begin
        r_x    <= (r_x == c_x_last) ? '0 : r_x + c_x_one;
        r_addr <= r_addr + c_addr_one;
      end else if (r_state == DRAIN) begin
        r_x <= (r_x == c_drain_last) ? '0 : r_x + c_x_one;
      end
    end
  end

  // Line tracking: frame_start rewinds, a clean completion advances or wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_line_cnt  <= '0;
      r_line_base <= '0;
    end else if (frame_start) begin
      r_line_cnt  <= '0;
      r_line_base <= '0;
    end else if (w_done && !r_skip) begin
      if (r_line_cnt == c_line_last) begin
        r_line_cnt  <= '0;
        r_line_base <= '0;
      end else begin
        r_line_cnt  <= r_line_cnt + c_line_one;
        r_line_base <= r_line_base + c_len;
      end
    end
  end

  // A fetch overtaken by frame_start must not advance the rewound counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_skip <= 1'b0;
    end else if (data_req) begin
      r_skip <= w_busy && !frame_start && r_skip;
    end else if (frame_start && w_busy) begin
      r_skip <= 1'b1;
    end else if (w_done) begin
      r_skip <= 1'b0;
    end
  end

  // Sticky overrun: a request landed while a fetch was still in flight.
  always_ff @(posedge clk) begin
    if (!rst_n)                r_overrun <= 1'b0;
    else if (data_req && w_busy) r_overrun <= 1'b1;
  end

  // Read-latency delay line turning fb_en into the linebuffer write enable.
  generate
    if (LAT == 1) begin : g_lat1
      always_ff @(posedge clk) begin
        if (!rst_n) r_dly <= '0;
        else        r_dly <= fb_en;
      end
    end else begin : g_latn
      always_ff @(posedge clk) begin
        if (!rst_n) r_dly <= '0;
        else        r_dly <= {r_dly[LAT-2:0], fb_en};
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/fb_line_fetch.md
# fb_line_fetch

Single-clock line fetcher that sits directly upstream of the display linebuffer in the system clock domain. On each linebuffer data request it reads one full line of pixels from the framebuffer BRAM, compensates for BRAM read latency, and drives the linebuffer's write enable and three channel data inputs. It tracks the current framebuffer line and wraps at frame end, so the linebuffer sees a continuous stream of consecutive lines.

## Interface
- WIDTH, 8: bits per colour channel.
- LEN, 160: pixels per line; equals the linebuffer LEN.
- LINES, 120: lines per frame.
- LAT, 1: framebuffer read latency in cycles, 1 or 2.
- ADDRW, $clog2(LEN*LINES): framebuffer address width.

- clk  input  1  system clock; the linebuffer clk_in domain.
- rst_n  input  1  reset; synchronous, active-low.
- frame_start  input  1  one-cycle pulse; next fetch reads line 0.
- data_req  input  1  one-cycle pulse from the linebuffer requesting the next line.
- fb_en  output  1  framebuffer read enable.
- fb_addr  output  ADDRW  framebuffer read address.
- fb_data  input  3*WIDTH  framebuffer read data, {ch2,ch1,ch0}, valid LAT cycles after fb_en.
- line_en  output  1  write enable to the linebuffer en_in.
- din_0, din_1, din_2  output  WIDTH  channel data to the linebuffer; din_0 is fb_data[WIDTH-1:0].
- busy  output  1  high while a fetch or its drain is in progress.
- overrun  output  1  sticky flag: data_req arrived while busy.

## Operation
- States are IDLE, FETCH and DRAIN.
- IDLE -> FETCH on data_req. The read address starts at line_base.
- FETCH issues one read per cycle: fb_en=1, fb_addr=line_base+x, for x=0..LEN-1. After x=LEN-1 the state goes to DRAIN.
- DRAIN waits LAT cycles for the last data, then returns to IDLE. On that exit:
  - line_base advances by LEN and line_cnt by 1.
  - At line_cnt==LINES-1, line_base and line_cnt wrap to 0.
- line_base is a running register. No multiplier is used. It never exceeds LEN*(LINES-1).
- line_en is fb_en delayed LAT cycles through a shift register. din_* are combinational slices of fb_data.
- data_req while busy (FETCH or DRAIN):
  - Set overrun.
  - Abort the current fetch without advancing line_cnt.
  - Restart FETCH of the same line at x=0 on the next cycle.
  - The linebuffer resets its write address on the same pulse, so the line is rewritten whole.
  - Reads already in the LAT pipeline still emerge as line_en and are accepted. Verification treats those LAT writes as don't-care.
- frame_start sets line_cnt=0 and line_base=0. It does not abort a fetch in progress, and the completing fetch does not advance the counters.
- frame_start and data_req in the same cycle: frame_start applies first, and the fetch reads line 0.
- overrun clears only on reset.
- Reset (rst_n=0 on a clock edge), including mid-fetch, sets:
  - State IDLE, x=0, line_cnt=0, line_base=0.
  - fb_en=0, fb_addr=0, line_en=0, delay line cleared.
  - busy=0, overrun=0.
  - din_* follow fb_data and have no reset value.

## Timing
- data_req sampled high at edge t.
- fb_en=1 and fb_addr=line_base in cycle t+1, through cycle t+LEN.
- line_en=1 in cycles t+1+LAT through t+LEN+LAT, exactly LEN cycles.
- busy is high from t+1 through t+LEN+LAT. The state is IDLE and busy=0 at t+LEN+LAT+1.
- Minimum spacing between data_req pulses without overrun: LEN+LAT+1 cycles. A linebuffer line period always exceeds this.

## Structure
- No shared package additions. The fetch_state_t enum (IDLE, FETCH, DRAIN) stays local.
- No sub-module. The LAT delay line and counters are inline.
- The framebuffer is an external bram_sdp instance owned by the top level.

## Test plan
- LEN=4, LINES=3, LAT=1, one data_req after reset -> fb_addr 0,1,2,3 in cycles t+1..t+4; line_en high t+2..t+5; din matches fb_data; busy low at t+6.
- Three spaced data_req pulses -> base addresses 0, 4, 8; a fourth pulse -> base wraps to 0.
- frame_start after the line-1 fetch, then data_req -> fetch starts at fb_addr 0.
- data_req at cycle t+2 of a fetch -> overrun=1; addresses restart at the same base; line_cnt is not advanced.
- rst_n=0 for one cycle mid-FETCH -> next cycle fb_en=0, line_en=0, busy=0, overrun=0; the next data_req fetches base 0.
- LAT=2 repeat of the first scenario -> line_en high t+3..t+6, exactly 4 cycles.
